gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Next-generation fetch-stage branch predictor: a gshare-indexed 2-bit pattern history table (PHT), a global history register (GHR), and a separate tagged, direct-mapped branch target buffer (BTB) that also tracks unconditional jumps. It supplies a same-cycle predicted next PC to IF. It is trained non-speculatively from the writeback/commit stage, gated by the pipeline's `load_buffers` advance strobe. It replaces the untagged, PC-indexed predictor.

## Interface
- `S_IDX`, 9, log2 of PHT entries
- `S_HIST`, 9, GHR width; legal range 1..`S_IDX`
- `S_BTB`, 6, log2 of BTB entries; tag is `pc[31:S_BTB+2]`
- `USE_XOR`, 1, 1 = gshare index; 0 = plain PC index (history still tracked)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset; one clock, synchronous, active-high
- `if_pc` in 32: fetch PC
- `if_pred_pc` out 32: predicted next fetch PC
- `if_pred_taken` out 1: prediction is a redirect
- `load_buffers` in 1: pipeline advancing; all updates are gated by it
- `upd_valid` in 1: a committed control-flow instruction is presented
- `upd_pc` in 32: its PC
- `upd_next_pc` in 32: its actual next PC
- `upd_is_br` in 1: conditional branch
- `upd_is_jmp` in 1: jal/jalr; mutually exclusive with `upd_is_br`
- `ghr` out `S_HIST`: current history, for debug and perf

## Operation
- PHT index:
  - `idx(pc) = pc[S_IDX+1:2] ^ {zero-extend(ghr)}` when `USE_XOR=1`.
  - Otherwise `pc[S_IDX+1:2]`.
  - PC bits [1:0] are never used.
- BTB entry fields: `valid`, `tag`, `target[31:0]`, `jmp`.
  - Entry index: `pc[S_BTB+1:2]`.
  - Hit: `valid && tag == pc[31:S_BTB+2]`.
- Prediction (combinational):
  - `if_pred_taken = hit && (jmp || pht[idx(if_pc)][1])`.
  - `if_pred_pc = if_pred_taken ? target : if_pc + 4`, with 32-bit wrap (0xFFFFFFFC+4 = 0).
- Update strobe: `upd = load_buffers && upd_valid && (upd_is_br || upd_is_jmp)`. All writes below happen at the posedge where `upd` is 1.
  - Actual direction: `taken = (upd_next_pc != upd_pc + 4)`.
  - Conditional branch, PHT: the entry at `idx(upd_pc)` is computed with the pre-edge GHR. It increments if taken, decrements if not, saturating at 00 and 11.
  - Conditional branch, GHR: `ghr <= {ghr[S_HIST-2:0], taken}`. For `S_HIST=1`, `ghr <= taken`.
  - Jump: PHT and GHR are unchanged.
  - BTB, when `taken`: write `valid=1`, the tag, `target=upd_next_pc`, `jmp=upd_is_jmp`. This overwrites any entry at that index, including an aliasing tag.
  - BTB, when not taken: unchanged. A not-taken branch never allocates.
- `upd_valid` with neither type bit set, or `load_buffers=0`: no state change.

## Timing
- Reset state:
  - every PHT counter = 2'b01 (weakly not-taken);
  - every BTB `valid` = 0;
  - `ghr` = 0.
- Resulting reset outputs: `if_pred_taken`=0 and `if_pred_pc=if_pc+4` in the first cycle after reset deasserts.
- `rst` dominates a simultaneous `upd`. Reset mid-run discards all trained state in one edge.
- Prediction latency is 0 cycles: outputs depend combinationally on `if_pc` and the current state.
- An update sampled at edge N is visible to predictions from edge N onward, i.e. the next cycle.
- Fetch and update in the same cycle: the prediction uses pre-update state. No bypass.
- Back-to-back updates to the same PHT or BTB index each see the prior edge's write. No read-modify-write hazard, because the read is combinational and the write is registered.
- No stall or backpressure output. The block accepts one update per cycle.

## Test plan
- Reset, then `if_pc=0x60` -> `if_pred_pc=0x64`, `if_pred_taken=0`, `ghr=0`. Repeat with `rst` asserted mid-run after training -> same result.
- `USE_XOR=0`, branch `upd_pc=0x100` -> `upd_next_pc=0x80`, one update -> next cycle `if_pc=0x100` gives `0x80`, taken=1, `ghr=0x001`.
- Same branch: 3 more taken, then 1 not-taken (`upd_next_pc=0x104`) -> still predicts `0x80`. One more not-taken -> counter 01 -> `if_pred_pc=0x104` although the BTB still hits.
- jal `upd_pc=0x200` -> `0x400`, one update -> `if_pc=0x200` predicts `0x400` immediately; `ghr` unchanged; PHT entry unchanged.
- BTB alias, `S_BTB=6`: train 0x100 -> 0x80, then `if_pc=0x200` (same BTB index, different tag) -> `0x204`, taken=0. Train 0x200 -> 0x300 -> `if_pc=0x100` now misses.
- `USE_XOR=1`: three taken branches -> `ghr=0b111`, and the next branch trains the entry at `pc[10:2]^0x007`. An `upd_valid=1` with `load_buffers=0` -> `ghr`, PHT and BTB unchanged. Fetch and update in the same cycle -> the prediction reflects the old counter.

Source files
------------

// File: rtl/gshare_predictor.sv
// Fetch-stage branch predictor: gshare-indexed 2-bit PHT, global history register
// and a tagged direct-mapped BTB, trained from commit under the load_buffers strobe.
module gshare_predictor #(
  parameter int S_IDX   = 9,
  parameter int S_HIST  = 9,
  parameter int S_BTB   = 6,
  parameter int USE_XOR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_pc,
  output logic [31:0]       if_pred_pc,
  output logic              if_pred_taken,
  input  logic              load_buffers,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_next_pc,
  input  logic              upd_is_br,
  input  logic              upd_is_jmp,
  output logic [S_HIST-1:0] ghr
);

  localparam int PHT_N = 1 << S_IDX;
  localparam int BTB_N = 1 << S_BTB;
  localparam int TAG_W = 30 - S_BTB;

  logic [1:0]       pht        [PHT_N];
  logic             btb_valid  [BTB_N];
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [31:0]      btb_target [BTB_N];
  logic             btb_jmp    [BTB_N];

  function automatic logic [S_IDX-1:0] pht_index(input logic [31:0] pc,
                                                 input logic [S_HIST-1:0] h);
    logic [S_IDX-1:0] i;
    i = pc[S_IDX+1:2];
    if (USE_XOR != 0) i = i ^ S_IDX'(h);
    return i;
  endfunction

  // Prediction path: purely combinational on if_pc and current state.
  logic [S_BTB-1:0] f_bi;
  logic             f_hit;
  logic [1:0]       f_ctr;

  always_comb begin
    f_bi          = if_pc[S_BTB+1:2];
    f_hit         = btb_valid[f_bi] && (btb_tag[f_bi] == if_pc[31:S_BTB+2]);
    f_ctr         = pht[pht_index(if_pc, ghr)];
    if_pred_taken = f_hit && (btb_jmp[f_bi] || f_ctr[1]);
    if_pred_pc    = if_pred_taken ? btb_target[f_bi] : if_pc + 32'd4;
  end

  // Training path.
  logic             upd;
  logic             act_taken;
  logic [S_IDX-1:0] u_idx;
  logic [S_BTB-1:0] u_bi;
  logic [1:0]       u_ctr;
  logic [1:0]       u_ctr_next;

  always_comb begin
    upd        = load_buffers && upd_valid && (upd_is_br || upd_is_jmp);
    act_taken  = (upd_next_pc != upd_pc + 32'd4);
    u_idx      = pht_index(upd_pc, ghr);
    u_bi       = upd_pc[S_BTB+1:2];
    u_ctr      = pht[u_idx];
    u_ctr_next = u_ctr;
    if (act_taken && u_ctr != 2'b11)       u_ctr_next = u_ctr + 2'b01;
    else if (!act_taken && u_ctr != 2'b00) u_ctr_next = u_ctr - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      for (int unsigned i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
      ghr <= '0;
    end else if (upd) begin
      if (upd_is_br) begin
        pht[u_idx] <= u_ctr_next;
        // Truncating {ghr, taken} to S_HIST bits also covers the 1-bit history case.
        ghr <= S_HIST'({ghr, act_taken});
      end
      if (act_taken) begin
        btb_valid[u_bi]  <= 1'b1;
        btb_tag[u_bi]    <= upd_pc[31:S_BTB+2];
        btb_target[u_bi] <= upd_next_pc;
        btb_jmp[u_bi]    <= upd_is_jmp;
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed vector table, a gshare hand sequence and
// randomized traffic against an arithmetic reference model, on XOR and PC-index builds.
module tb_gshare_predictor;

  logic        clk;
  logic        rst, load_buffers, upd_valid, upd_is_br, upd_is_jmp;
  logic [31:0] if_pc, upd_pc, upd_next_pc;
  logic [31:0] p_pc [2];
  logic        p_tk [2];
  logic [8:0]  g    [2];

  gshare_predictor #(.S_IDX(9), .S_HIST(9), .S_BTB(6), .USE_XOR(0)) dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_pc(p_pc[0]), .if_pred_taken(p_tk[0]),
    .load_buffers(load_buffers), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_next_pc(upd_next_pc), .upd_is_br(upd_is_br), .upd_is_jmp(upd_is_jmp), .ghr(g[0]));

  gshare_predictor #(.S_IDX(9), .S_HIST(9), .S_BTB(6), .USE_XOR(1)) dut1 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_pc(p_pc[1]), .if_pred_taken(p_tk[1]),
    .load_buffers(load_buffers), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_next_pc(upd_next_pc), .upd_is_br(upd_is_br), .upd_is_jmp(upd_is_jmp), .ghr(g[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: counters held as integers 0..3, history as an integer mod 512.
  int unsigned m_pht [2][512];
  int unsigned m_ghr [2];
  bit          m_v   [64];
  int unsigned m_tag [64];
  logic [31:0] m_tgt [64];
  bit          m_j   [64];
  bit          m_init = 0;

  function automatic int unsigned m_idx(int x, logic [31:0] pc);
    return ((pc / 4) % 512) ^ ((x == 1) ? m_ghr[x] : 0);
  endfunction

  task automatic check_model(input string tag);
    int unsigned b;
    bit hit, tk;
    logic [31:0] npc;
    if (!m_init) return;
    b   = (if_pc / 4) % 64;
    hit = m_v[b] && (m_tag[b] == if_pc / 256);
    for (int x = 0; x < 2; x++) begin
      tk  = hit && (m_j[b] || m_pht[x][m_idx(x, if_pc)] >= 2);
      npc = tk ? m_tgt[b] : if_pc + 32'd4;
      chk($sformatf("%s dut%0d taken pc=%h", tag, x, if_pc), 32'(p_tk[x]), 32'(tk));
      chk($sformatf("%s dut%0d pred_pc pc=%h", tag, x, if_pc), p_pc[x], npc);
      chk($sformatf("%s dut%0d ghr", tag, x), 32'(g[x]), m_ghr[x]);
    end
  endtask

  task automatic edge_update();
    bit t;
    int unsigned b, i;
    if (rst) begin
      for (int x = 0; x < 2; x++) begin
        m_ghr[x] = 0;
        for (int k = 0; k < 512; k++) m_pht[x][k] = 1;
      end
      for (int k = 0; k < 64; k++) m_v[k] = 0;
      m_init = 1;
    end else if (load_buffers && upd_valid && (upd_is_br || upd_is_jmp)) begin
      t = (upd_next_pc != upd_pc + 32'd4);
      if (upd_is_br)
        for (int x = 0; x < 2; x++) begin
          i = m_idx(x, upd_pc);
          if (t) m_pht[x][i] = (m_pht[x][i] == 3) ? 3 : m_pht[x][i] + 1;
          else   m_pht[x][i] = (m_pht[x][i] == 0) ? 0 : m_pht[x][i] - 1;
          m_ghr[x] = (m_ghr[x] * 2 + t) % 512;
        end
      if (t) begin
        b = (upd_pc / 4) % 64;
        m_v[b] = 1; m_tag[b] = upd_pc / 256; m_tgt[b] = upd_next_pc; m_j[b] = upd_is_jmp;
      end
    end
  endtask

  typedef struct {
    bit rst, lb, uv, br, jmp;
    logic [31:0] upc, unext, ifpc;
    bit chk;
    bit etk;
    logic [31:0] epc;
    logic [8:0] eghr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit lb, bit uv, bit br, bit jmp, logic [31:0] upc,
                              logic [31:0] unext, logic [31:0] ifpc, bit c, bit etk,
                              logic [31:0] epc, logic [8:0] eghr);
    vec_t v;
    v.rst = r; v.lb = lb; v.uv = uv; v.br = br; v.jmp = jmp;
    v.upc = upc; v.unext = unext; v.ifpc = ifpc;
    v.chk = c; v.etk = etk; v.epc = epc; v.eghr = eghr;
    tbl.push_back(v);
  endfunction

  function automatic void idle(logic [31:0] ifpc, bit etk, logic [31:0] epc, logic [8:0] eghr);
    add(0, 0, 0, 0, 0, 0, 0, ifpc, 1, etk, epc, eghr);
  endfunction

  task automatic do_cycle(input vec_t v, input string tag);
    rst = v.rst; load_buffers = v.lb; upd_valid = v.uv; upd_is_br = v.br;
    upd_is_jmp = v.jmp; upd_pc = v.upc; upd_next_pc = v.unext; if_pc = v.ifpc;
    @(negedge clk);
    if (v.chk) begin
      chk({tag, " taken"}, 32'(p_tk[0]), 32'(v.etk));
      chk({tag, " pred_pc"}, p_pc[0], v.epc);
      chk({tag, " ghr"}, 32'(g[0]), 32'(v.eghr));
    end
    check_model(tag);
    @(posedge clk);
    edge_update();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1; load_buffers = 0; upd_valid = 0; upd_is_br = 0; upd_is_jmp = 0;
    upd_pc = 0; upd_next_pc = 0; if_pc = 0;
    @(posedge clk); #1;

    // Expectations below are for the PC-indexed build (dut0).
    add(1, 0, 0, 0, 0, 0, 0, 32'h60, 0, 0, 0, 0);
    idle(32'h60, 0, 32'h64, 9'h000);
    add(0, 1, 1, 1, 0, 32'h100, 32'h80, 32'h100, 1, 0, 32'h104, 9'h000);
    idle(32'h100, 1, 32'h80, 9'h001);
    add(0, 1, 1, 1, 0, 32'h100, 32'h80, 32'h100, 1, 1, 32'h80, 9'h001);
    add(0, 1, 1, 1, 0, 32'h100, 32'h80, 32'h100, 1, 1, 32'h80, 9'h003);
    add(0, 1, 1, 1, 0, 32'h100, 32'h80, 32'h100, 1, 1, 32'h80, 9'h007);
    add(0, 1, 1, 1, 0, 32'h100, 32'h104, 32'h100, 1, 1, 32'h80, 9'h00F);
    idle(32'h100, 1, 32'h80, 9'h01E);
    add(0, 1, 1, 1, 0, 32'h100, 32'h104, 32'h100, 1, 1, 32'h80, 9'h01E);
    idle(32'h100, 0, 32'h104, 9'h03C);
    add(0, 1, 1, 0, 1, 32'h200, 32'h400, 32'h200, 1, 0, 32'h204, 9'h03C);
    idle(32'h200, 1, 32'h400, 9'h03C);
    idle(32'h100, 0, 32'h104, 9'h03C);
    add(0, 0, 1, 1, 0, 32'h300, 32'h500, 32'h300, 1, 0, 32'h304, 9'h03C);
    idle(32'h300, 0, 32'h304, 9'h03C);
    add(0, 1, 1, 0, 0, 32'h300, 32'h500, 32'h300, 1, 0, 32'h304, 9'h03C);
    idle(32'h300, 0, 32'h304, 9'h03C);
    idle(32'hFFFF_FFFC, 0, 32'h0, 9'h03C);
    add(1, 1, 1, 1, 0, 32'h100, 32'h80, 32'h200, 1, 1, 32'h400, 9'h03C);
    idle(32'h200, 0, 32'h204, 9'h000);
    idle(32'h100, 0, 32'h104, 9'h000);
    idle(32'h60, 0, 32'h64, 9'h000);
    add(0, 1, 1, 1, 0, 32'h100, 32'h80, 32'h60, 1, 0, 32'h64, 9'h000);
    add(0, 1, 1, 1, 0, 32'h200, 32'h300, 32'h200, 1, 0, 32'h204, 9'h001);
    idle(32'h100, 0, 32'h104, 9'h003);
    idle(32'h200, 1, 32'h300, 9'h003);

    for (int r = 0; r < tbl.size(); r++) do_cycle(tbl[r], $sformatf("vec%0d", r));

    // gshare: three taken branches walk the XOR index through 0x40, 0x41, 0x43;
    // the fourth lookup at 0x100 lands on untouched entry 0x47.
    v = tbl[0]; v.chk = 0;
    do_cycle(v, "x_rst");
    v.rst = 0; v.lb = 1; v.uv = 1; v.br = 1; v.upc = 32'h100; v.unext = 32'h80; v.ifpc = 32'h100;
    for (int k = 0; k < 3; k++) do_cycle(v, $sformatf("x_tr%0d", k));
    rst = 0; load_buffers = 0; upd_valid = 0; if_pc = 32'h100;
    @(negedge clk);
    chk("xor ghr", 32'(g[1]), 32'h007);
    chk("xor pred_pc", p_pc[1], 32'h104);
    chk("xor taken", 32'(p_tk[1]), 32'h0);
    chk("pcidx pred_pc", p_pc[0], 32'h80);
    @(posedge clk); edge_update(); #1;

    for (int n = 0; n < 3000; n++) begin
      int unsigned sel;
      v.rst = ($urandom_range(0, 299) == 0);
      v.lb  = ($urandom_range(0, 7) != 0);
      v.uv  = ($urandom_range(0, 5) != 0);
      sel   = $urandom_range(0, 3);
      v.br  = (sel == 0 || sel == 3);
      v.jmp = (sel == 1);
      v.upc = $urandom_range(0, 255) * 16 + $urandom_range(0, 3) * 4;
      v.unext = $urandom_range(0, 1) ? v.upc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
      v.ifpc = $urandom_range(0, 2) == 0 ? (($urandom() & 32'h3FC)) : v.upc;
      v.chk = 0;
      do_cycle(v, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
